// File: rtl/mux_stream_pkg.sv
// -----------------------------------------------------------------------------
// mux_stream_pkg
// Shared types, mode encodings and the rotating-priority search helper used by
// the N-channel streaming multiplexer (mux_stream_n) and its arbiter.
//
// Contents:
//   lock_state_t : packet-lock FSM states (IDLE, LOCKED)
//   MODE_MANUAL  : mode encoding for external select
//   MODE_RR      : mode encoding for round-robin arbitration
//   rr_pick()    : returns the first valid channel after ptr, with wrap at n
// -----------------------------------------------------------------------------
package mux_stream_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Largest supported channel count; the helper works on this fixed width.
    localparam int MAX_N = 16;

    typedef struct packed {
        logic [3:0] idx;
        logic       found;
    } rr_pick_t;

    // Search ptr+1, ptr+2, ... modulo n and return the first set valid bit.
    function automatic rr_pick_t rr_pick(input logic [MAX_N-1:0] valid,
                                         input logic [3:0]       ptr,
                                         input int               n);
        rr_pick_t   res;
        int         c;
        logic [3:0] ci;
        res.idx   = 4'd0;
        res.found = 1'b0;
        for (int k = 1; k <= MAX_N; k++) begin
            c  = (int'({28'd0, ptr}) + k) % n;
            ci = 4'(c);
            if ((k <= n) && !res.found && valid[ci]) begin
                res.idx   = ci;
                res.found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority picker. The channel after ptr has the highest
// priority; the search wraps modulo N. The pointer register lives in the parent.
//
// Parameters:
//   N           : number of requesters (2..16)
// Ports:
//   valid       in  N     request vector
//   ptr         in  SELW  last granted channel
//   grant       out SELW  winning channel index
//   grant_valid out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import mux_stream_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    rr_pick_t pick_s;

    // Rotating search starting at the channel after the pointer
    always_comb begin
        pick_s      = rr_pick(MAX_N'(valid), 4'(ptr), N);
        grant       = SELW'(pick_s.idx);
        grant_valid = pick_s.found;
    end

endmodule

// File: rtl/mux_stream_n.sv
// -----------------------------------------------------------------------------
// mux_stream_n
// N-channel, W-bit streaming multiplexer with per-channel valid/ready inputs
// and a registered valid/ready output stage. Selection is either manual
// (external sel) or round-robin across requesting channels. The index of the
// channel that supplied each output beat is reported on out_ch.
//
// Optional feature (macro MUX_STREAM_PKT_LOCK_EN): once a beat with
// in_last=0 is accepted, the granting channel stays locked until its beat
// with in_last=1 is accepted, so packets are never interleaved.
//
// Parameters:
//   N, W        : channel count (2..16), data width
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   mode        : 0 manual, 1 round-robin
//   sel         : manual channel index (sel >= N grants nothing)
//   in_data     : channel i at [i*W +: W]
//   in_last     : per-channel end-of-packet
//   in_valid    : per-channel valid
//   in_ready    : per-channel ready (one-hot or zero)
//   out_data    : registered data
//   out_last    : registered end-of-packet
//   out_ch      : source channel of out_data
//   out_valid   : output valid
//   out_ready   : downstream ready
// -----------------------------------------------------------------------------
module mux_stream_n
    import mux_stream_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int W    = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [N*W-1:0]    in_data,
    input  logic [N-1:0]      in_last,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [W-1:0]      out_data,
    output logic              out_last,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    logic            load_s;
    logic            consume_s;
    logic            sel_valid_s;
    logic            locked_s;
    logic            arb_valid_s;
    logic            grant_valid_s;
    logic            grant_in_valid_s;
    logic            grant_in_last_s;
    logic [SELW-1:0] arb_grant_s;
    logic [SELW-1:0] lock_ch_s;
    logic [SELW-1:0] grant_s;
    logic [W-1:0]    grant_data_s;
    logic [N-1:0]    in_ready_s;

    logic [SELW-1:0] rr_ptr_r;
    logic [W-1:0]    out_data_r;
    logic            out_last_r;
    logic [SELW-1:0] out_ch_r;
    logic            out_valid_r;

    rr_arbiter #(.N(N)) u_arb (
        .valid       (in_valid),
        .ptr         (rr_ptr_r),
        .grant       (arb_grant_s),
        .grant_valid (arb_valid_s)
    );

    // The output register can take a new beat when empty or being drained.
    assign load_s      = !out_valid_r || out_ready;
    assign sel_valid_s = (32'(sel) < N);

`ifdef MUX_STREAM_PKT_LOCK_EN
    lock_state_t     state_r;
    lock_state_t     state_nxt_s;
    logic [SELW-1:0] lock_ch_r;
    logic [SELW-1:0] lock_ch_nxt_s;

    assign locked_s  = (state_r == LOCKED);
    assign lock_ch_s = lock_ch_r;

    // Packet-lock next state: lock on a non-final beat, release on the last one
    always_comb begin
        state_nxt_s   = state_r;
        lock_ch_nxt_s = lock_ch_r;
        case (state_r)
            IDLE: begin
                if (consume_s && !grant_in_last_s) begin
                    state_nxt_s   = LOCKED;
                    lock_ch_nxt_s = grant_s;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            LOCKED: begin
                if (consume_s && grant_in_last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Packet-lock state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            lock_ch_r <= {SELW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            lock_ch_r <= lock_ch_nxt_s;
        end
    end
`else
    assign locked_s  = 1'b0;
    assign lock_ch_s = {SELW{1'b0}};
`endif

    // Grant source: locked channel first, then the mode-selected policy
    always_comb begin
        grant_s       = {SELW{1'b0}};
        grant_valid_s = 1'b0;
        if (locked_s) begin
            grant_s       = lock_ch_s;
            grant_valid_s = 1'b1;
        end else if (mode == MODE_RR) begin
            grant_s       = arb_grant_s;
            grant_valid_s = arb_valid_s;
        end else begin
            grant_s       = sel;
            grant_valid_s = sel_valid_s;
        end
    end

    // AND-OR channel mux; an out-of-range grant selects nothing
    always_comb begin
        grant_data_s     = {W{1'b0}};
        grant_in_valid_s = 1'b0;
        grant_in_last_s  = 1'b0;
        for (int i = 0; i < N; i++) begin
            grant_data_s     = grant_data_s | (in_data[i*W +: W] & {W{grant_s == SELW'(i)}});
            grant_in_valid_s = grant_in_valid_s | (in_valid[i] & (grant_s == SELW'(i)));
            grant_in_last_s  = grant_in_last_s  | (in_last[i]  & (grant_s == SELW'(i)));
        end
    end

    // Ready goes only to the granted channel, and never during reset
    always_comb begin
        in_ready_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            in_ready_s[i] = !reset && load_s && grant_valid_s && (grant_s == SELW'(i));
        end
    end

    assign consume_s = !reset && load_s && grant_valid_s && grant_in_valid_s;
    assign in_ready  = in_ready_s;

    // Output stage and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_r  <= {W{1'b0}};
            out_last_r  <= 1'b0;
            out_ch_r    <= {SELW{1'b0}};
            out_valid_r <= 1'b0;
            rr_ptr_r    <= SELW'(N - 1);
        end else begin
            if (consume_s) begin
                out_data_r  <= grant_data_s;
                out_last_r  <= grant_in_last_s;
                out_ch_r    <= grant_s;
                out_valid_r <= 1'b1;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (consume_s && (mode == MODE_RR)) begin
                rr_ptr_r <= grant_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_ch    = out_ch_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_stream_n.sv
// Directed bench for mux_stream_n: a 4-channel instance exercises reset,
// round-robin, manual select, backpressure and packet behaviour; a 5-channel
// instance exercises the out-of-range select.
module tb_mux_stream_n;

    logic        clk = 1'b0;
    logic        reset;

    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic        mode5;
    logic [2:0]  sel5;
    logic [39:0] in_data5;
    logic [4:0]  in_last5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic [7:0]  out_data5;
    logic        out_last5;
    logic [2:0]  out_ch5;
    logic        out_valid5;
    logic        out_ready5;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mux_stream_n #(.N(4), .W(8)) dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel),
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_stream_n #(.N(5), .W(8)) dut5 (
        .clk(clk), .reset(reset), .mode(mode5), .sel(sel5),
        .in_data(in_data5), .in_last(in_last5), .in_valid(in_valid5),
        .in_ready(in_ready5), .out_data(out_data5), .out_last(out_last5),
        .out_ch(out_ch5), .out_valid(out_valid5), .out_ready(out_ready5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   exp_ch[5];
        int   exp_last[5];
        int   cnt1;
        logic rdy1;

`ifdef MUX_STREAM_PKT_LOCK_EN
        exp_ch   = '{1, 1, 1, 2, 0};
        exp_last = '{0, 0, 1, 1, 1};
`else
        exp_ch   = '{1, 2, 0, 1, 2};
        exp_last = '{0, 1, 1, 0, 1};
`endif

        // Reset held two cycles with every channel requesting
        reset      = 1'b1;
        mode       = 1'b1;
        sel        = 2'd0;
        in_data    = {8'h44, 8'h33, 8'h22, 8'h11};
        in_last    = 4'b0000;
        in_valid   = 4'hF;
        out_ready  = 1'b1;
        mode5      = 1'b0;
        sel5       = 3'd5;
        in_data5   = {8'hE4, 8'hD3, 8'hC2, 8'hB1, 8'hA0};
        in_last5   = 5'b00000;
        in_valid5  = 5'h1F;
        out_ready5 = 1'b1;
        #1;
        chk("rst_in_ready_pre", 32'(in_ready), 32'h0);
        chk("rst_in_ready5_pre", 32'(in_ready5), 32'h0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_out_data", 32'(out_data), 32'h0);
            chk("rst_out_ch", 32'(out_ch), 32'h0);
            chk("rst_in_ready", 32'(in_ready), 32'h0);
        end

        // Round-robin, all valid: ch0 first, then strict rotation
        reset = 1'b0;
        #1;
        chk("rr_first_ready", 32'(in_ready), 32'h1);
        chk("sel5_oob_ready", 32'(in_ready5), 32'h0);
        for (int b = 0; b < 8; b++) begin
            tick();
            chk("rr_out_valid", 32'(out_valid), 32'h1);
            chk("rr_out_ch", 32'(out_ch), 32'(b % 4));
            chk("rr_out_data", 32'(out_data), 32'(8'h11 * ((b % 4) + 1)));
        end
        chk("sel5_oob_no_beat", 32'(out_valid5), 32'h0);

        // Highest in-range select on the 5-channel instance
        sel5 = 3'd4;
        #1;
        chk("sel5_ch4_ready", 32'(in_ready5), 32'h10);
        tick();
        chk("sel5_ch4_ch", 32'(out_ch5), 32'h4);
        chk("sel5_ch4_data", 32'(out_data5), 32'hE4);

        // Manual select of channel 2
        mode     = 1'b0;
        sel      = 2'd2;
        in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
        in_valid = 4'b0100;
        #1;
        chk("man_ready", 32'(in_ready), 32'h4);
        tick();
        chk("man_out_valid", 32'(out_valid), 32'h1);
        chk("man_out_data", 32'(out_data), 32'hA5);
        chk("man_out_ch", 32'(out_ch), 32'h2);

        // Backpressure: 3C captured, then held for five stalled cycles
        in_data = {8'h44, 8'h3C, 8'h22, 8'h11};
        tick();
        chk("bp_capture", 32'(out_data), 32'h3C);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_data = {8'h44, 8'(8'h70 + c), 8'h22, 8'h11};
            #1;
            chk("bp_ready", 32'(in_ready), 32'h0);
            tick();
            chk("bp_hold_data", 32'(out_data), 32'h3C);
            chk("bp_hold_valid", 32'(out_valid), 32'h1);
            chk("bp_hold_ch", 32'(out_ch), 32'h2);
        end
        out_ready = 1'b1;
        in_data   = {8'h44, 8'h5A, 8'h22, 8'h11};
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'h4);
        tick();
        chk("bp_release_data", 32'(out_data), 32'h5A);

        // Reset while a beat is held under backpressure
        out_ready = 1'b0;
        in_data   = {8'h44, 8'h66, 8'h22, 8'h11};
        tick();
        chk("hold_before_rst", 32'(out_data), 32'h5A);
        reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(in_ready), 32'h0);
        tick();
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_data", 32'(out_data), 32'h0);
        reset     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        tick();
        chk("post_rst_idle", 32'(out_valid), 32'h0);

        // Packet test: one ch0 beat moves the pointer so ch1 wins next
        mode     = 1'b1;
        in_data  = {8'h44, 8'h30, 8'h20, 8'h10};
        in_last  = 4'b0101;
        in_valid = 4'b0001;
        tick();
        chk("pkt_prime_ch", 32'(out_ch), 32'h0);
        cnt1 = 0;
        for (int b = 0; b < 5; b++) begin
            in_valid = 4'b0111;
            in_last  = {1'b0, 1'b1, (cnt1 == 2), 1'b1};
            #1;
            rdy1 = in_ready[1];
            tick();
            if (rdy1) cnt1++;
            chk("pkt_out_ch", 32'(out_ch), 32'(exp_ch[b]));
            chk("pkt_out_last", 32'(out_last), 32'(exp_last[b]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
